round_referee: RTL

Round referee for the two-player tile game: consumes the per-player hit flags from the pixel generator and produces the movement-enable and round-win signals consumed by the top level, the player blocks and the score counters. It holds a start countdown, per-player lives, post-hit stun windows and a one-cycle round-end event. Its AWin/BWin outputs feed the score counters directly, so each win is a single-cycle pulse.

---
 rtl/round_referee.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/round_referee.sv
// Round referee: start countdown, per-player lives and stun windows, and a
// single-cycle round-end event (AWin/BWin/draw) for the score counters.
module round_referee #(
  parameter int unsigned LIVES        = 3,
  parameter int unsigned START_CYCLES = 25_000_000,
  parameter int unsigned STUN_CYCLES  = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hitA,
  input  logic       hitB,
  output logic       ACanMove,
  output logic       BCanMove,
  output logic       AWin,
  output logic       BWin,
  output logic       draw,
  output logic [2:0] livesA,
  output logic [2:0] livesB
);

  localparam int unsigned MAX_CYC = (START_CYCLES > STUN_CYCLES) ? START_CYCLES : STUN_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CYC);
  localparam int unsigned LW      = 3;

  localparam logic [CW-1:0] START_LOAD = CW'(START_CYCLES - 1);
  localparam logic [CW-1:0] STUN_LOAD  = CW'(STUN_CYCLES - 1);
  localparam logic [LW-1:0] LIVES_INIT = LW'(LIVES);

  typedef enum logic [1:0] {
    READY = 2'd0,
    PLAY  = 2'd1,
    OVER  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] stuna_q, stuna_d;
  logic [CW-1:0] stunb_q, stunb_d;
  logic [LW-1:0] livesa_q, livesa_d;
  logic [LW-1:0] livesb_q, livesb_d;
  logic          hita_q, hitb_q;
  logic          acan_q, acan_d;
  logic          bcan_q, bcan_d;
  logic          awin_q, awin_d;
  logic          bwin_q, bwin_d;
  logic          draw_q, draw_d;

  logic ev_a, ev_b;
  logic take_a, take_b;
  logic out_a, out_b;

  // Rising-edge hit events; a hit only counts when the player is not stunned.
  assign ev_a   = hitA & ~hita_q;
  assign ev_b   = hitB & ~hitb_q;
  assign take_a = ev_a & (stuna_q == '0);
  assign take_b = ev_b & (stunb_q == '0);
  assign out_a  = take_a & (livesa_q == LW'(1));
  assign out_b  = take_b & (livesb_q == LW'(1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stuna_d  = stuna_q;
    stunb_d  = stunb_q;
    livesa_d = livesa_q;
    livesb_d = livesb_q;
    awin_d   = 1'b0;
    bwin_d   = 1'b0;
    draw_d   = 1'b0;

    case (state_q)
      READY: begin
        if (cnt_q == '0) state_d = PLAY;
        else             cnt_d   = cnt_q - CW'(1);
      end
      PLAY: begin
        if (stuna_q != '0) stuna_d = stuna_q - CW'(1);
        if (stunb_q != '0) stunb_d = stunb_q - CW'(1);
        if (take_a) begin
          livesa_d = livesa_q - LW'(1);
          stuna_d  = STUN_LOAD;
        end
        if (take_b) begin
          livesb_d = livesb_q - LW'(1);
          stunb_d  = STUN_LOAD;
        end
        if (out_a || out_b) begin
          state_d = OVER;
          draw_d  = out_a & out_b;
          bwin_d  = out_a & ~out_b;
          awin_d  = out_b & ~out_a;
        end
      end
      OVER: begin
        state_d  = READY;
        cnt_d    = START_LOAD;
        stuna_d  = '0;
        stunb_d  = '0;
        livesa_d = LIVES_INIT;
        livesb_d = LIVES_INIT;
      end
      default: state_d = READY;
    endcase

    // Enable stays low through the cycle in which the stun counter reaches zero,
    // giving a stun window of exactly STUN_CYCLES cycles.
    acan_d = (state_d == PLAY) && (stuna_q == '0) && (stuna_d == '0);
    bcan_d = (state_d == PLAY) && (stunb_q == '0) && (stunb_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= READY;
      cnt_q    <= START_LOAD;
      stuna_q  <= '0;
      stunb_q  <= '0;
      livesa_q <= LIVES_INIT;
      livesb_q <= LIVES_INIT;
      hita_q   <= 1'b0;
      hitb_q   <= 1'b0;
      acan_q   <= 1'b0;
      bcan_q   <= 1'b0;
      awin_q   <= 1'b0;
      bwin_q   <= 1'b0;
      draw_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stuna_q  <= stuna_d;
      stunb_q  <= stunb_d;
      livesa_q <= livesa_d;
      livesb_q <= livesb_d;
      hita_q   <= hitA;
      hitb_q   <= hitB;
      acan_q   <= acan_d;
      bcan_q   <= bcan_d;
      awin_q   <= awin_d;
      bwin_q   <= bwin_d;
      draw_q   <= draw_d;
    end
  end

  assign ACanMove = acan_q;
  assign BCanMove = bcan_q;
  assign AWin     = awin_q;
  assign BWin     = bwin_q;
  assign draw     = draw_q;
  assign livesA   = livesa_q;
  assign livesB   = livesb_q;

endmodule
